// File: rtl/ram_host_pkg.sv
// rtl/ram_host_pkg.sv - shared response type and address constants for the RAM host adapter
package ram_host_pkg;

    // Byte address bits below the 32-bit word index
    localparam int unsigned ADDR_LSB = 2;

    // One response record as queued towards the host
    typedef struct packed {
        logic [31:0] rdata;
        logic        we;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/ram_host_rsp_fifo.sv
// rtl/ram_host_rsp_fifo.sv - response FIFO with zero-latency head and occupancy count
module ram_host_rsp_fifo
    import ram_host_pkg::*;
#(
    parameter int unsigned RspDepth = 2,
    localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1,
    localparam int unsigned CntW = $clog2(RspDepth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  rsp_t            push_data_i,
    input  logic            pop_i,
    output logic            valid_o,
    output rsp_t            head_o,
    output logic [CntW-1:0] count_o
);

    rsp_t            mem_q [RspDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign valid_o = (count_q != '0);
    assign pop_ok  = pop_i && valid_o;
    // Payload reads as zero when empty so nothing stale leaks out after reset
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // Next pointers and count; simultaneous push and pop leave the count unchanged
    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and count state, emptied by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Upstream credit accounting must never push into a full FIFO
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_ok && count_q == CntW'(RspDepth)));

endmodule

// File: rtl/ram_host_adapter.sv
// rtl/ram_host_adapter.sv - host request to 1-cycle RAM port adapter with in-order responses
module ram_host_adapter
    import ram_host_pkg::*;
#(
    parameter int unsigned Depth    = 128,
    parameter int unsigned RspDepth = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [3:0]  host_be_i,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_gnt_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_we_o,
    output logic        rsp_err_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    localparam int unsigned CntW  = $clog2(RspDepth + 1);
    localparam int unsigned OccW  = CntW + 1;
    localparam int unsigned WordW = 32 - ADDR_LSB;

    logic            out_of_range;
    logic            accept;
    logic            pop;
    logic            inflight_valid_q, inflight_valid_d;
    logic            inflight_we_q, inflight_we_d;
    logic            inflight_err_q, inflight_err_d;
    logic [CntW-1:0] fifo_count;
    logic            fifo_valid;
    rsp_t            fifo_head;
    rsp_t            push_data;
    logic [OccW-1:0] occupancy;

    // Comparing the word index against Depth rejects every byte address >= 4*Depth
    assign out_of_range = host_addr_i[31:ADDR_LSB] >= WordW'(Depth);

    // Credit: queued plus in-flight responses, less the one leaving this cycle
    assign pop        = fifo_valid && rsp_ready_i;
    assign occupancy  = OccW'(fifo_count) + OccW'(inflight_valid_q) - OccW'(pop);
    assign host_gnt_o = !rst_i && (occupancy < OccW'(RspDepth));
    assign accept     = host_req_i && host_gnt_o;

    // RAM port driven only for accepted in-range requests, zero otherwise
    assign ram_req_o   = accept && !out_of_range;
    assign ram_we_o    = ram_req_o && host_we_i;
    assign ram_be_o    = ram_req_o ? host_be_i    : '0;
    assign ram_addr_o  = ram_req_o ? host_addr_i  : '0;
    assign ram_wdata_o = ram_req_o ? host_wdata_i : '0;

    // Capture each accepted request; the slot empties when nothing new is accepted
    always_comb begin
        inflight_valid_d = accept;
        inflight_we_d    = accept && host_we_i;
        inflight_err_d   = accept && out_of_range;
    end

    // In-flight register, dropped on reset so its response is never pushed
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_valid_q <= 1'b0;
            inflight_we_q    <= 1'b0;
            inflight_err_q   <= 1'b0;
        end else begin
            inflight_valid_q <= inflight_valid_d;
            inflight_we_q    <= inflight_we_d;
            inflight_err_q   <= inflight_err_d;
        end
    end

    // Build the response pushed one cycle after acceptance
    always_comb begin
        push_data = '0;
        if (inflight_err_q) begin
            push_data.we  = inflight_we_q;
            push_data.err = 1'b1;
        end else if (inflight_we_q) begin
            push_data.we = 1'b1;
        end else begin
            push_data.rdata = ram_rdata_i;
        end
    end

    ram_host_rsp_fifo #(
        .RspDepth (RspDepth)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_valid_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign rsp_valid_o = fifo_valid;
    assign rsp_rdata_o = fifo_head.rdata;
    assign rsp_we_o    = fifo_head.we;
    assign rsp_err_o   = fifo_head.err;

    // The RAM answers exactly the requests it was sent, one cycle later
    a_ram_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        ram_rvalid_i == (inflight_valid_q && !inflight_err_q));

endmodule

// File: doc/ram_host_adapter.md
RAM_HOST_ADAPTER -- requirements
Module: ram_host_adapter

Interface
REQ-001 Parameter: Depth, 128, RAM depth in 32-bit words; in-range byte addresses are 0 .. 4*Depth-1.
REQ-002 Parameter: RspDepth, 2, response FIFO entries, minimum 2.
REQ-003 Port: clk_i  in  1  sole clock; all logic is rising-edge.
REQ-004 Port: rst_i  in  1  asynchronous, active-high reset.
REQ-005 Ports: host_req_i in 1, host_we_i in 1, host_be_i in 4, host_addr_i in 32, host_wdata_i in 32; host request.
REQ-006 Port: host_gnt_o  out  1  request accepted this cycle when host_req_i && host_gnt_o.
REQ-007 Ports: rsp_valid_o out 1, rsp_ready_i in 1, rsp_rdata_o out 32, rsp_we_o out 1, rsp_err_o out 1; response channel, transfer on valid && ready.
REQ-008 Ports: ram_req_o out 1, ram_we_o out 1, ram_be_o out 4, ram_addr_o out 32, ram_wdata_o out 32; drive one port of the 1-cycle dual-port RAM.
REQ-009 Ports: ram_rvalid_i in 1, ram_rdata_i in 32; RAM response, exactly one cycle after each ram_req_o, for reads and writes alike.

Function
REQ-010 A request is out of range when host_addr_i >= 4*Depth; low two address bits are ignored.
REQ-011 On an accepted in-range request, the block asserts ram_req_o combinationally in the same cycle, with we/be/addr/wdata passed through unchanged.
REQ-012 ram_req_o is 0 for an out-of-range request and in every cycle without an accepted request.
REQ-013 An in-flight register (valid, we, err) captures every accepted request and clears the next cycle unless a new request is accepted.
REQ-014 The response is pushed into the FIFO in the cycle after acceptance, regardless of rsp_ready_i.
REQ-015 Response content: in-range read -> rdata=ram_rdata_i, we=0, err=0; in-range write -> rdata=0, we=1, err=0; out-of-range -> rdata=0, we=host_we_i, err=1.
REQ-016 Responses are returned strictly in request order, including error responses.
REQ-017 Credit rule: host_gnt_o = (fifo_count + inflight_valid - pop) < RspDepth, where pop = rsp_valid_o && rsp_ready_i; the FIFO never overflows.
REQ-018 host_gnt_o is independent of host_req_i and is 0 while rst_i is high.
REQ-019 Sustained throughput is one request per cycle when rsp_ready_i is held at 1.
REQ-020 rsp_valid_o = FIFO not empty; rsp_rdata_o, rsp_we_o and rsp_err_o show the FIFO head with zero-latency read.
REQ-021 Response payload is held stable while rsp_valid_o && !rsp_ready_i.
REQ-022 In a cycle with a simultaneous push and pop, the count is unchanged; on an empty FIFO, the response appears no earlier than the cycle after the push (no bypass).
REQ-023 Minimum latency from request to rsp_valid_o is 2 cycles.
REQ-024 ram_rvalid_i must equal inflight_valid && !inflight_err; a mismatch fires an assertion.

Reset
REQ-025 Asserting rst_i clears the FIFO (empty, pointers 0) and inflight_valid.
REQ-026 While rst_i is asserted: rsp_valid_o=0, host_gnt_o=0, ram_req_o=0, and remaining outputs are 0.
REQ-027 A response for an in-flight request interrupted by reset is discarded and never presented.
REQ-028 The block accepts a request in the first cycle after rst_i deasserts.

Structure
REQ-029 Package ram_host_pkg holds the rsp_t struct {rdata[31:0], we, err} and the constant for the byte-address LSB width (2).
REQ-030 Sub-module ram_host_rsp_fifo is a synchronous FIFO of rsp_t, parameterised by RspDepth, with count output and asynchronous active-high reset.
REQ-031 The top level holds only the range check, in-flight register, credit logic and RAM drive.

Verification
REQ-032 Read 0x10 with rsp_ready_i=1 (RAM word 4 = 0xDEADBEEF) -> ram_req_o in cycle 0; cycle 2: rsp_valid_o=1, rdata=0xDEADBEEF, err=0.
REQ-033 Write 0x8, be=0b0011, wdata=0x12345678, then read 0x8 (word previously 0) -> write response we=1; read returns 0x00005678.
REQ-034 Read 0x200 with Depth=128 -> ram_req_o stays 0; response err=1, rdata=0; a neighbouring in-range response keeps its order.
REQ-035 rsp_ready_i=0, host_req_i held at 1 -> exactly RspDepth grants issue, then host_gnt_o=0; on release, order is preserved and back-to-back throughput resumes.
REQ-036 rst_i pulsed in the cycle after an accepted read -> no response emerges; rsp_valid_o=0, and host_gnt_o=1 in the first cycle after release.
REQ-037 Random traffic, 10k requests, random rsp_ready_i -> scoreboard matches a memory model; no overflow; REQ-024 assertion never fires.
